// File: rtl/hex_scan_scheduler.sv
// hex_scan_scheduler: time-shares one nibble decoder across NUM_DIGITS positions.
// Slots are loaded via valid/ready; a lit slot cannot be rewritten until its GAP.
module hex_scan_scheduler #(
   parameter int NUM_DIGITS = 6,
   parameter int IDX_W      = 3,
   parameter int SCAN_DIV   = 50000,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [IDX_W-1:0]      wr_addr,
   input  logic [3:0]            wr_data,
   input  logic                  wr_blank,
   output logic                  wr_err,
   output logic [3:0]            scan_nibble,
   output logic                  scan_blank,
   output logic [NUM_DIGITS-1:0] scan_sel,
   output logic [IDX_W-1:0]      scan_idx,
   output logic                  frame_done
);
   localparam int MAXC  = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
   localparam int CNT_W = $clog2(MAXC + 1);

   typedef enum logic {GAP, SHOW} state_t;

   state_t                  r_state, w_state_nx;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
   logic [IDX_W-1:0]        r_idx, w_idx_nx;
   logic [NUM_DIGITS*4-1:0] r_val;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic                    r_err;
   logic                    w_gap_end, w_show_end, w_acc, w_oor;

   assign w_gap_end  = (r_state == GAP)  && (r_cnt == CNT_W'(GAP_CYCLES - 1));
   assign w_show_end = (r_state == SHOW) && (r_cnt == CNT_W'(SCAN_DIV - 1));
   assign wr_ready   = !((r_state == SHOW) && (wr_addr == r_idx));
   assign w_acc      = wr_valid && wr_ready && !RESET;
   assign w_oor      = {1'b0, wr_addr} >= (IDX_W+1)'(NUM_DIGITS);
   assign scan_idx   = r_idx;
   assign wr_err     = r_err;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_state <= GAP;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 1'b1;
      w_idx_nx   = r_idx;
      if (w_gap_end) begin
         w_state_nx = SHOW;
         w_cnt_nx   = '0;
      end else if (w_show_end) begin
         w_state_nx = GAP;
         w_cnt_nx   = '0;
         w_idx_nx   = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end
   end

   // Out-of-range addresses match no slot, so they only raise wr_err.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_val   <= '0;
         r_blank <= '1;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_acc && w_oor;
         for (int i = 0; i < NUM_DIGITS; i++)
            if (w_acc && (wr_addr == IDX_W'(i))) begin
               r_val[i*4 +: 4] <= wr_data;
               r_blank[i]      <= wr_blank;
            end
      end
   end

   always_comb begin
      scan_sel    = '0;
      scan_nibble = 4'h0;
      scan_blank  = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if ((r_state == SHOW) && (r_idx == IDX_W'(i))) begin
            scan_sel[i] = 1'b1;
            scan_nibble = r_val[i*4 +: 4];
            scan_blank  = r_blank[i];
         end
      frame_done = w_show_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
   end
endmodule
